id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage sitting directly downstream of the register file in the single-threaded 5-stage pipeline. It captures register-file read data, immediate and decode controls on the rising clock edge and applies EX/MEM bypassing to both operands at capture time. It detects load-use hazards, stalls IF/ID and inserts a bubble. It also honours branch flushes and keeps a saturating stall counter for debug.

## Interface

Parameters:
- `W`, 32: datapath width.
- `CNTW`, 16: stall counter width.

Ports:
- `CLK`, in, 1: clock. Capture on posedge; the register file writes on negedge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `id_valid`, in, 1: decode holds a real instruction.
- `id_pc`, in, W: PC of the decode instruction.
- `id_rs`, `id_rt`, `id_rd`, in, 5 each: source and destination register fields.
- `id_usesRt`, in, 1: instruction reads rt (R-type, store, branch).
- `readData1`, `readData2`, in, W: register-file read data. Register 0 reads as 0.
- `id_imm`, in, W: sign/zero-extended immediate.
- `id_regShouldWrite`, `id_regToWrite`, `id_memRead`, `id_memWrite`, `id_aluSrc`, in, 1 each: decode controls.
- `id_aluOp`, in, 4: ALU operation.
- `ex_aluResult`, in, W: combinational ALU result of the instruction currently in EX.
- `mem_valid`, `mem_regShouldWrite`, in, 1 each; `mem_writeReg`, in, 5; `mem_result`, in, W: MEM-stage writeback info.
- `ex_flush`, in, 1: branch/jump taken, kill the decode instruction.
- `stall`, out, 1: combinational. Hold PC and IF/ID.
- `ex_valid`, out, 1; `ex_pc`, out, W; `ex_opA`, `ex_opB`, out, W; `ex_storeData`, out, W; `ex_writeReg`, out, 5.
- `ex_regShouldWrite`, `ex_memRead`, `ex_memWrite`, out, 1 each; `ex_aluOp`, out, 4.
- `stall_count`, out, CNTW: saturating count of stall cycles.

## Operation

- Destination select: `id_writeReg = id_regToWrite ? id_rd : id_rt`.
- Load-use hazard condition: `ex_valid && ex_memRead && ex_writeReg != 0`, and either `ex_writeReg == id_rs` or (`id_usesRt && ex_writeReg == id_rt`).
- `stall` is asserted when `id_valid`, the load-use hazard condition holds, and `!ex_flush`.
- Bypass for each source register `r` (rs, rt), at capture, in priority order:
  1. EX match: `ex_valid && ex_regShouldWrite && !ex_memRead && ex_writeReg == r && r != 0` selects `ex_aluResult`.
  2. MEM match: `mem_valid && mem_regShouldWrite && mem_writeReg == r && r != 0` selects `mem_result`.
  3. Otherwise `readData1` / `readData2`. WB needs no bypass because the register file writes on the preceding negedge.
- Operand mapping:
  - `ex_opA` = bypassed rs.
  - `ex_storeData` = bypassed rt.
  - `ex_opB` = `id_aluSrc ? id_imm : bypassed rt`.
- Capture priority on each posedge:
  1. `ex_flush` or `stall` or `!id_valid` loads a bubble: `ex_valid`, `ex_regShouldWrite`, `ex_memRead`, `ex_memWrite` = 0; datapath fields = 0.
  2. Otherwise all fields load from ID with `ex_valid` = 1.
- `stall_count` increments on each posedge where `stall` = 1. It saturates at all-ones and never wraps.

## Timing

- Latency is 1 cycle: ID values appear on `ex_*` after the next posedge.
- A load-use stall lasts exactly 1 cycle. The bubble enters EX, after which the load is in MEM and the MEM bypass resolves the dependency.
- Flush and stall together: flush wins, `stall` = 0, bubble inserted.
- Reset, asynchronous and also mid-operation:
  - All `ex_*` outputs and `stall_count` go to 0 immediately.
  - `stall` = 0 while Reset is high, since `ex_valid` = 0.
  - Normal capture resumes on the first posedge after Reset falls.
- Source register 0 never bypasses and never triggers a hazard.

## Structure

- Shared package `cpu_pkg`: ALU op encodings, `REG_ZERO` = 5'd0, width constant `W`, bubble control constant.
- Sub-module `hazard_detect` (combinational): produces `stall` and the two 2-bit bypass selects. `id_ex_stage` holds the muxes and registers.

## Test plan

- Reset asserted mid-stream with `ex_valid` = 1 → all `ex_*` = 0 and `stall_count` = 0 before the next edge.
- ADD r3 in EX (`ex_aluResult` = 0x00000010) with SUB using rs = r3 in ID and `readData1` = 0x5 → `ex_opA` = 0x10 after the edge.
- r4 written by both EX (0xAA) and MEM (0xBB), ID reads r4 as rt with `id_aluSrc` = 0 → `ex_opB` = 0xAA, and `ex_storeData` = 0xAA.
- LW r5 in EX, next instruction uses rt = r5 with `id_usesRt` = 1 → `stall` = 1 for one cycle, bubble (`ex_valid` = 0), then the instruction is captured with the MEM bypass value and `stall_count` = 1.
- Load-use hazard together with `ex_flush` = 1 → `stall` = 0, bubble captured, `stall_count` unchanged.
- Source r0 while EX writes r0 with 0xFFFF → `ex_opA` = `readData1` = 0 and no stall. Holding a hazard for 2^CNTW + 3 cycles → `stall_count` saturates at 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU op encodings, register-0 constant, datapath width
// and the control bundle that a bubble loads into EX.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_LUI = 4'd9
  } aluOp_e;

  typedef enum logic [1:0] {
    BYP_REG = 2'd0,
    BYP_EX  = 2'd1,
    BYP_MEM = 2'd2
  } bypSel_e;

  typedef struct packed {
    logic       valid;
    logic       regShouldWrite;
    logic       memRead;
    logic       memWrite;
    logic [3:0] aluOp;
  } exCtrl_t;

  localparam exCtrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use stall and operand bypass selection for the ID/EX boundary.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       idValid,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       exValid,
  input  logic       exRegShouldWrite,
  input  logic       exMemRead,
  input  logic [4:0] exWriteReg,
  input  logic       memValid,
  input  logic       memRegShouldWrite,
  input  logic [4:0] memWriteReg,
  input  logic       exFlush,
  output logic       stall,
  output bypSel_e    selRs,
  output bypSel_e    selRt
);

  logic exFwdOk;
  logic memFwdOk;
  logic loadUse;

  // A load in EX has no result yet, so it can never be the EX bypass source.
  assign exFwdOk  = exValid && exRegShouldWrite && !exMemRead && (exWriteReg != REG_ZERO);
  assign memFwdOk = memValid && memRegShouldWrite && (memWriteReg != REG_ZERO);

  always_comb begin
    selRs = BYP_REG;
    selRt = BYP_REG;
    if (exFwdOk && (exWriteReg == idRs))        selRs = BYP_EX;
    else if (memFwdOk && (memWriteReg == idRs)) selRs = BYP_MEM;
    if (exFwdOk && (exWriteReg == idRt))        selRt = BYP_EX;
    else if (memFwdOk && (memWriteReg == idRt)) selRt = BYP_MEM;
  end

  assign loadUse = exValid && exMemRead && (exWriteReg != REG_ZERO) &&
                   ((exWriteReg == idRs) || (idUsesRt && (exWriteReg == idRt)));

  assign stall = idValid && loadUse && !exFlush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time bypassing, load-use bubble insertion,
// branch flush and a saturating stall counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            id_valid,
  input  logic [W-1:0]    id_pc,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic            id_usesRt,
  input  logic [W-1:0]    readData1,
  input  logic [W-1:0]    readData2,
  input  logic [W-1:0]    id_imm,
  input  logic            id_regShouldWrite,
  input  logic            id_regToWrite,
  input  logic            id_memRead,
  input  logic            id_memWrite,
  input  logic            id_aluSrc,
  input  logic [3:0]      id_aluOp,
  input  logic [W-1:0]    ex_aluResult,
  input  logic            mem_valid,
  input  logic            mem_regShouldWrite,
  input  logic [4:0]      mem_writeReg,
  input  logic [W-1:0]    mem_result,
  input  logic            ex_flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [W-1:0]    ex_pc,
  output logic [W-1:0]    ex_opA,
  output logic [W-1:0]    ex_opB,
  output logic [W-1:0]    ex_storeData,
  output logic [4:0]      ex_writeReg,
  output logic            ex_regShouldWrite,
  output logic            ex_memRead,
  output logic            ex_memWrite,
  output logic [3:0]      ex_aluOp,
  output logic [CNTW-1:0] stall_count
);

  bypSel_e      selRs;
  bypSel_e      selRt;
  logic [W-1:0] fwdRs;
  logic [W-1:0] fwdRt;
  logic [4:0]   idWriteReg;
  logic         capture;

  hazard_detect u_hazard (
    .idValid           (id_valid),
    .idRs              (id_rs),
    .idRt              (id_rt),
    .idUsesRt          (id_usesRt),
    .exValid           (ex_valid),
    .exRegShouldWrite  (ex_regShouldWrite),
    .exMemRead         (ex_memRead),
    .exWriteReg        (ex_writeReg),
    .memValid          (mem_valid),
    .memRegShouldWrite (mem_regShouldWrite),
    .memWriteReg       (mem_writeReg),
    .exFlush           (ex_flush),
    .stall             (stall),
    .selRs             (selRs),
    .selRt             (selRt)
  );

  always_comb begin
    case (selRs)
      BYP_EX:  fwdRs = ex_aluResult;
      BYP_MEM: fwdRs = mem_result;
      default: fwdRs = readData1;
    endcase
    case (selRt)
      BYP_EX:  fwdRt = ex_aluResult;
      BYP_MEM: fwdRt = mem_result;
      default: fwdRt = readData2;
    endcase
  end

  assign idWriteReg = id_regToWrite ? id_rd : id_rt;
  assign capture    = id_valid && !stall && !ex_flush;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      {ex_valid, ex_regShouldWrite, ex_memRead, ex_memWrite, ex_aluOp} <= BUBBLE_CTRL;
      ex_pc        <= '0;
      ex_opA       <= '0;
      ex_opB       <= '0;
      ex_storeData <= '0;
      ex_writeReg  <= REG_ZERO;
    end else if (!capture) begin
      {ex_valid, ex_regShouldWrite, ex_memRead, ex_memWrite, ex_aluOp} <= BUBBLE_CTRL;
      ex_pc        <= '0;
      ex_opA       <= '0;
      ex_opB       <= '0;
      ex_storeData <= '0;
      ex_writeReg  <= REG_ZERO;
    end else begin
      ex_valid          <= 1'b1;
      ex_regShouldWrite <= id_regShouldWrite;
      ex_memRead        <= id_memRead;
      ex_memWrite       <= id_memWrite;
      ex_aluOp          <= id_aluOp;
      ex_pc             <= id_pc;
      ex_opA            <= fwdRs;
      ex_opB            <= id_aluSrc ? id_imm : fwdRt;
      ex_storeData      <= fwdRt;
      ex_writeReg       <= idWriteReg;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                              stall_count <= '0;
    else if (stall && (stall_count != '1))  stall_count <= stall_count + CNTW'(1);
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver predicts each cycle from a behavioural
// pipeline model and queues it; an independent monitor pops and compares.
module tb_id_ex_stage;

  localparam int TW   = 32;
  localparam int TCNT = 8;
  localparam logic [TCNT-1:0] CNT_MAX = {TCNT{1'b1}};

  logic            CLK;
  logic            Reset;
  logic            id_valid;
  logic [TW-1:0]   id_pc;
  logic [4:0]      id_rs, id_rt, id_rd;
  logic            id_usesRt;
  logic [TW-1:0]   readData1, readData2, id_imm;
  logic            id_regShouldWrite, id_regToWrite, id_memRead, id_memWrite, id_aluSrc;
  logic [3:0]      id_aluOp;
  logic [TW-1:0]   ex_aluResult;
  logic            mem_valid, mem_regShouldWrite;
  logic [4:0]      mem_writeReg;
  logic [TW-1:0]   mem_result;
  logic            ex_flush;
  logic            stall;
  logic            ex_valid;
  logic [TW-1:0]   ex_pc, ex_opA, ex_opB, ex_storeData;
  logic [4:0]      ex_writeReg;
  logic            ex_regShouldWrite, ex_memRead, ex_memWrite;
  logic [3:0]      ex_aluOp;
  logic [TCNT-1:0] stall_count;

  id_ex_stage #(.W(TW), .CNTW(TCNT)) dut (
    .CLK(CLK), .Reset(Reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_usesRt(id_usesRt), .readData1(readData1), .readData2(readData2), .id_imm(id_imm),
    .id_regShouldWrite(id_regShouldWrite), .id_regToWrite(id_regToWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_aluSrc(id_aluSrc),
    .id_aluOp(id_aluOp), .ex_aluResult(ex_aluResult),
    .mem_valid(mem_valid), .mem_regShouldWrite(mem_regShouldWrite),
    .mem_writeReg(mem_writeReg), .mem_result(mem_result), .ex_flush(ex_flush),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opA(ex_opA), .ex_opB(ex_opB),
    .ex_storeData(ex_storeData), .ex_writeReg(ex_writeReg),
    .ex_regShouldWrite(ex_regShouldWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_aluOp(ex_aluOp), .stall_count(stall_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        idValid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic        usesRt;
    logic [31:0] rd1, rd2, imm;
    logic        rsw, regToWrite, memRead, memWrite, aluSrc;
    logic [3:0]  aluOp;
    logic [31:0] aluRes;
    logic        memValid, memRsw;
    logic [4:0]  memReg;
    logic [31:0] memRes;
    logic        flush;
  } stim_t;

  // Contents of the EX stage after an edge, plus the stall seen before that edge.
  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] pc, opA, opB, sd;
    logic [4:0]  wr;
    logic        rsw, mr, mw;
    logic [3:0]  op;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       expQ[$];
  exp_t       mdl;
  logic [7:0] mdlCnt;
  int         nCmp = 0;
  int         nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic stim_t mkNop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Value a source register holds once younger results are taken into account:
  // the instruction in EX is newest, then MEM, then the register file.
  function automatic logic [31:0] srcValue(input logic [4:0] r, input logic [31:0] regVal,
                                           input stim_t s);
    if (r == 5'd0) return regVal;
    if (mdl.valid && mdl.rsw && !mdl.mr && mdl.wr == r) return s.aluRes;
    if (s.memValid && s.memRsw && s.memReg == r) return s.memRes;
    return regVal;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    logic needsLoad;
    @(negedge CLK);
    id_valid = s.idValid;  id_pc = s.pc;  id_rs = s.rs;  id_rt = s.rt;  id_rd = s.rd;
    id_usesRt = s.usesRt;  readData1 = s.rd1;  readData2 = s.rd2;  id_imm = s.imm;
    id_regShouldWrite = s.rsw;  id_regToWrite = s.regToWrite;  id_memRead = s.memRead;
    id_memWrite = s.memWrite;  id_aluSrc = s.aluSrc;  id_aluOp = s.aluOp;
    ex_aluResult = s.aluRes;  mem_valid = s.memValid;  mem_regShouldWrite = s.memRsw;
    mem_writeReg = s.memReg;  mem_result = s.memRes;  ex_flush = s.flush;

    needsLoad = mdl.valid && mdl.mr && mdl.wr != 5'd0 &&
                (mdl.wr == s.rs || (s.usesRt && mdl.wr == s.rt));
    e = '{default: '0};
    e.stall = s.idValid && needsLoad && !s.flush;
    if (s.idValid && !s.flush && !e.stall) begin
      e.valid = 1'b1;
      e.pc    = s.pc;
      e.opA   = srcValue(s.rs, s.rd1, s);
      e.sd    = srcValue(s.rt, s.rd2, s);
      e.opB   = s.aluSrc ? s.imm : e.sd;
      e.wr    = s.regToWrite ? s.rd : s.rt;
      e.rsw   = s.rsw;
      e.mr    = s.memRead;
      e.mw    = s.memWrite;
      e.op    = s.aluOp;
    end
    if (e.stall && mdlCnt != CNT_MAX) mdlCnt = mdlCnt + 8'd1;
    e.cnt = mdlCnt;
    mdl = e;
    expQ.push_back(e);
  endtask

  function automatic stim_t mkRand();
    stim_t s;
    s = mkNop();
    s.idValid    = ($urandom_range(0, 9) != 0);
    s.pc         = $urandom & 32'hFFFF_FFFC;
    s.rs         = 5'($urandom_range(0, 3));
    s.rt         = 5'($urandom_range(0, 3));
    s.rd         = 5'($urandom_range(0, 3));
    s.usesRt     = 1'($urandom_range(0, 1));
    s.rd1        = (s.rs == 5'd0) ? 32'd0 : $urandom;
    s.rd2        = (s.rt == 5'd0) ? 32'd0 : $urandom;
    s.imm        = $urandom;
    s.rsw        = 1'($urandom_range(0, 1));
    s.regToWrite = 1'($urandom_range(0, 1));
    s.memRead    = ($urandom_range(0, 2) == 0);
    s.memWrite   = 1'($urandom_range(0, 1));
    s.aluSrc     = 1'($urandom_range(0, 1));
    s.aluOp      = 4'($urandom_range(0, 9));
    s.aluRes     = $urandom;
    s.memValid   = 1'($urandom_range(0, 1));
    s.memRsw     = 1'($urandom_range(0, 1));
    s.memReg     = 5'($urandom_range(0, 3));
    s.memRes     = $urandom;
    s.flush      = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    logic sStall;
    forever begin
      @(negedge CLK);
      #3;
      if (expQ.size() != 0) begin
        sStall = stall;
        @(posedge CLK);
        #1;
        e = expQ.pop_front();
        chk("stall", {31'd0, sStall}, {31'd0, e.stall});
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_opA", ex_opA, e.opA);
        chk("ex_opB", ex_opB, e.opB);
        chk("ex_storeData", ex_storeData, e.sd);
        chk("ex_writeReg", {27'd0, ex_writeReg}, {27'd0, e.wr});
        chk("ex_ctrl", {29'd0, ex_regShouldWrite, ex_memRead, ex_memWrite},
            {29'd0, e.rsw, e.mr, e.mw});
        chk("ex_aluOp", {28'd0, ex_aluOp}, {28'd0, e.op});
        chk("stall_count", {24'd0, stall_count}, {24'd0, e.cnt});
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 8 && expQ.size() != 0; i++) begin
      @(posedge CLK);
      #2;
    end
    chk("scoreboard drained", expQ.size(), 0);
  endtask

  task automatic postEdge();
    @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    stim_t s;
    mdl    = '{default: '0};
    mdlCnt = 8'd0;
    Reset  = 1'b1;
    id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_usesRt = 0;
    readData1 = 0; readData2 = 0; id_imm = 0; id_regShouldWrite = 0; id_regToWrite = 0;
    id_memRead = 0; id_memWrite = 0; id_aluSrc = 0; id_aluOp = 0; ex_aluResult = 0;
    mem_valid = 0; mem_regShouldWrite = 0; mem_writeReg = 0; mem_result = 0; ex_flush = 0;
    repeat (3) @(posedge CLK);
    #2;
    Reset = 1'b0;
    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset stall_count", {24'd0, stall_count}, 32'd0);

    // ADD r3 then SUB reading r3: EX bypass.
    s = mkNop(); s.idValid = 1; s.pc = 32'h100; s.rs = 1; s.rt = 2; s.rd = 3;
    s.regToWrite = 1; s.rsw = 1; s.aluOp = 4'd0; s.rd1 = 7; s.rd2 = 9;
    drive(s);
    s = mkNop(); s.idValid = 1; s.pc = 32'h104; s.rs = 3; s.rt = 2; s.rd = 4;
    s.regToWrite = 1; s.rsw = 1; s.aluOp = 4'd1; s.rd1 = 5; s.rd2 = 9; s.aluRes = 32'h10;
    drive(s);
    postEdge();
    chk("EX bypass opA", ex_opA, 32'h10);

    // r4 produced by both EX and MEM: EX is younger and wins.
    s = mkNop(); s.idValid = 1; s.pc = 32'h108; s.rs = 1; s.rt = 4; s.rd = 6; s.usesRt = 1;
    s.regToWrite = 1; s.rsw = 1; s.rd2 = 32'h44; s.aluRes = 32'hAA;
    s.memValid = 1; s.memRsw = 1; s.memReg = 4; s.memRes = 32'hBB;
    drive(s);
    postEdge();
    chk("EX over MEM opB", ex_opB, 32'hAA);
    chk("EX over MEM storeData", ex_storeData, 32'hAA);

    // LW r5 then a user of r5 via rt: one stall, bubble, then MEM bypass.
    s = mkNop(); s.idValid = 1; s.pc = 32'h10C; s.rs = 1; s.rt = 5; s.memRead = 1;
    s.rsw = 1; s.aluSrc = 1; s.imm = 8;
    drive(s);
    s = mkNop(); s.idValid = 1; s.pc = 32'h110; s.rs = 2; s.rt = 5; s.rd = 7; s.usesRt = 1;
    s.regToWrite = 1; s.rsw = 1; s.rd2 = 32'h55;
    drive(s);
    #1;
    chk("load-use stall", {31'd0, stall}, 32'd1);
    postEdge();
    chk("load-use bubble", {31'd0, ex_valid}, 32'd0);
    s.memValid = 1; s.memRsw = 1; s.memReg = 5; s.memRes = 32'h1234;
    drive(s);
    #1;
    chk("stall released", {31'd0, stall}, 32'd0);
    postEdge();
    chk("MEM bypass opB", ex_opB, 32'h1234);
    chk("stall_count after one stall", {24'd0, stall_count}, 32'd1);

    // Load-use together with a flush: flush wins.
    s = mkNop(); s.idValid = 1; s.pc = 32'h114; s.rs = 1; s.rt = 6; s.memRead = 1; s.rsw = 1;
    drive(s);
    s = mkNop(); s.idValid = 1; s.pc = 32'h118; s.rs = 6; s.rt = 2; s.flush = 1;
    drive(s);
    #1;
    chk("flush suppresses stall", {31'd0, stall}, 32'd0);
    postEdge();
    chk("flush bubble", {31'd0, ex_valid}, 32'd0);
    chk("flush keeps count", {24'd0, stall_count}, 32'd1);

    // r0 never bypasses nor stalls.
    s = mkNop(); s.idValid = 1; s.pc = 32'h11C; s.rs = 1; s.rd = 0; s.regToWrite = 1; s.rsw = 1;
    drive(s);
    s = mkNop(); s.idValid = 1; s.pc = 32'h120; s.rs = 0; s.rt = 0; s.usesRt = 1;
    s.aluRes = 32'hFFFF;
    drive(s);
    postEdge();
    chk("r0 no bypass", ex_opA, 32'd0);
    s = mkNop(); s.idValid = 1; s.pc = 32'h124; s.rs = 1; s.rt = 0; s.memRead = 1; s.rsw = 1;
    drive(s);
    s = mkNop(); s.idValid = 1; s.pc = 32'h128; s.rs = 0; s.rt = 0; s.usesRt = 1;
    drive(s);
    #1;
    chk("r0 no stall", {31'd0, stall}, 32'd0);
    drain();

    for (int i = 0; i < 400; i++) drive(mkRand());
    drain();

    // Alternate load / dependent use to push the counter past saturation.
    for (int i = 0; i < 260; i++) begin
      s = mkNop(); s.idValid = 1; s.rs = 1; s.rt = 7; s.memRead = 1; s.rsw = 1;
      drive(s);
      s = mkNop(); s.idValid = 1; s.rs = 7; s.rt = 2; s.rd = 3; s.regToWrite = 1; s.rsw = 1;
      drive(s);
    end
    drain();
    chk("stall_count saturated", {24'd0, stall_count}, {24'd0, CNT_MAX});

    // Mid-stream asynchronous reset while EX holds a real instruction.
    s = mkNop(); s.idValid = 1; s.pc = 32'h200; s.rs = 2; s.rt = 3; s.rd = 3;
    s.regToWrite = 1; s.rsw = 1; s.rd1 = 32'hCAFE; s.rd2 = 32'hBEEF;
    drive(s);
    drain();
    chk("pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("async reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async reset ex_opA", ex_opA, 32'd0);
    chk("async reset ex_pc", ex_pc, 32'd0);
    chk("async reset stall_count", {24'd0, stall_count}, 32'd0);
    chk("async reset stall", {31'd0, stall}, 32'd0);
    postEdge();
    chk("reset held ex_valid", {31'd0, ex_valid}, 32'd0);
    Reset  = 1'b0;
    mdl    = '{default: '0};
    mdlCnt = 8'd0;
    for (int i = 0; i < 40; i++) drive(mkRand());
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
